// File: rtl/multdiv_ctrl.sv
// multdiv_ctrl: sequencer between the execute stage and a shared multi-cycle
// multiplier/divider.
//
// Captures one mult/div request from execute and freezes the front of the
// pipe while it runs. It pulses the unit's start strobe once, then waits for
// the result or a timeout. It finishes with a single writeback request, or
// with a write of an exception code to r30.
//
// Ports
//   clock, reset       : rising-edge clock, synchronous active-high reset
//   isMult, isDiv      : execute-stage op decode (both high = illegal, ignored)
//   flush              : kill any in-flight operation / block a new one
//   opA, opB, rd       : execute-stage operands and destination
//   md_result          : result from the multiplier/divider
//   md_exception       : unit reports overflow / divide-by-zero
//   md_resultRDY       : md_result valid this cycle
//   stall              : freeze fetch/decode/execute
//   ctrl_MULT/ctrl_DIV : one-cycle start strobes to the unit
//   md_opA, md_opB     : latched operands to the unit
//   wb_valid, wb_rd,
//   wb_data            : writeback request
//   busy               : controller is not idle
module multdiv_ctrl #(
  parameter int TIMEOUT  = 63,
  parameter int EXC_MULT = 4,
  parameter int EXC_DIV  = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        isMult,
  input  logic        isDiv,
  input  logic        flush,
  input  logic [31:0] opA,
  input  logic [31:0] opB,
  input  logic [4:0]  rd,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_resultRDY,
  output logic        stall,
  output logic        ctrl_MULT,
  output logic        ctrl_DIV,
  output logic [31:0] md_opA,
  output logic [31:0] md_opB,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, START, BUSY, DONE} state_t;

  localparam logic [5:0]  TO_CNT   = 6'(TIMEOUT);
  localparam logic [31:0] EXC_M_W  = 32'(EXC_MULT);
  localparam logic [31:0] EXC_D_W  = 32'(EXC_DIV);
  localparam logic [4:0]  EXC_REG  = 5'd30;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] opa_q, opa_d;
  logic [31:0] opb_q, opb_d;
  logic [4:0]  rd_q, rd_d;
  logic        div_q, div_d;
  logic [31:0] res_q, res_d;
  logic        exc_q, exc_d;

  logic        req;
  logic [5:0]  cnt_inc;

  // Reset also blocks a request so that stall stays low while reset is held.
  assign req     = (isMult ^ isDiv) & ~flush & ~reset;
  // Saturating increment. The counter holds the number of BUSY cycles
  // completed so far. Timeout is judged on the post-increment value, so the
  // forced completion lands on the TIMEOUT-th BUSY cycle.
  assign cnt_inc = (cnt_q == 6'd63) ? cnt_q : cnt_q + 6'd1;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      rd_q    <= '0;
      div_q   <= 1'b0;
      res_q   <= '0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      rd_q    <= rd_d;
      div_q   <= div_d;
      res_q   <= res_d;
      exc_q   <= exc_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    rd_d      = rd_q;
    div_d     = div_q;
    res_d     = res_q;
    exc_d     = exc_q;
    stall     = 1'b0;
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    wb_valid  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req) begin
          stall   = 1'b1;
          opa_d   = opA;
          opb_d   = opB;
          rd_d    = rd;
          div_d   = isDiv;
          exc_d   = 1'b0;
          state_d = START;
        end
      end
      START: begin
        stall = 1'b1;
        if (flush) begin
          state_d = IDLE;
        end else begin
          ctrl_MULT = ~div_q;
          ctrl_DIV  = div_q;
          cnt_d     = '0;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        stall = 1'b1;
        cnt_d = cnt_inc;
        if (flush) begin
          state_d = IDLE;
        end else if (md_resultRDY) begin
          // A result on the timeout cycle still wins over the forced exception.
          res_d   = md_result;
          exc_d   = md_exception;
          state_d = DONE;
        end else if (cnt_inc == TO_CNT) begin
          exc_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        // A normal result aimed at r0 is dropped; an exception always writes r30.
        wb_valid = ~flush & (exc_q | (rd_q != 5'd0));
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign md_opA  = opa_q;
  assign md_opB  = opb_q;
  assign busy    = (state_q != IDLE);
  assign wb_rd   = !wb_valid ? 5'd0  : (exc_q ? EXC_REG : rd_q);
  assign wb_data = !wb_valid ? 32'd0 : (exc_q ? (div_q ? EXC_D_W : EXC_M_W) : res_q);

endmodule
